// File: rtl/breakout_pkg.sv
// breakout_pkg: shared screen geometry, paddle band, frame-tick line and game state type.
// Used by: ball_engine (import breakout_pkg::*).
package breakout_pkg;
   localparam int H_VISIBLE       = 640;
   localparam int V_VISIBLE       = 480;
   localparam int PADDLE_Y_TOP    = 441;
   localparam int PADDLE_Y_BOT    = 449;
   localparam int PADDLE_W        = 100;
   localparam int FRAME_TICK_LINE = 480;
   typedef enum logic [1:0] {SERVE, PLAY, LOST, OVER} state_e;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus rising-edge pulse for a raw push-button.
// Ports: clk, rst_n (async active-low), btn_in (raw async button), rise (one-cycle pulse per press).
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic rise
);
   // [0] and [1] are the synchroniser stages, [2] holds the previous synchronised level
   logic [2:0] sh_q, sh_d;
   always_comb sh_d = {sh_q[1:0], btn_in};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sh_q <= '0;
      else        sh_q <= sh_d;
   assign rise = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball position/velocity, serve/play/lose sequencing, lives and per-pixel ball colour.
// Ports: CLK_25MH pixel clock; RST_N async active-low reset; hor_count/ver_count raster counters;
//        paddle_pos paddle left x; btn_launch raw launch button; rgb_out registered ball colour;
//        ball_x/ball_y ball top-left; lives remaining lives; game_over high in OVER.
// Option: define BALL_SPEEDUP_EN to raise the speed by one every 8th paddle hit (max 7).
module ball_engine
   import breakout_pkg::*;
#(
   parameter int         BALL_SIZE  = 8,
   parameter int         SPEED      = 2,
   parameter int         LIVES_INIT = 3,
   parameter logic [2:0] BALL_RGB   = 3'b010
) (
   input  logic       CLK_25MH,
   input  logic       RST_N,
   input  logic [9:0] hor_count,
   input  logic [9:0] ver_count,
   input  logic [9:0] paddle_pos,
   input  logic       btn_launch,
   output logic [2:0] rgb_out,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [1:0] lives,
   output logic       game_over
);
   localparam logic signed [10:0] X_MAX   = 11'(H_VISIBLE - BALL_SIZE);
   localparam logic signed [10:0] Y_BOT   = 11'(V_VISIBLE - BALL_SIZE);
   localparam logic [9:0]         Y_SERVE = 10'(PADDLE_Y_TOP - 1 - BALL_SIZE);
   localparam logic [10:0]        SRV_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);

   state_e            state_q, state_d;
   logic [9:0]        x_q, x_d, y_q, y_d, px, serve_x;
   logic              dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d, press_q, press_d;
   logic [1:0]        lives_q, lives_d;
   logic [2:0]        rgb_q, rgb_d, spd;
   logic              tick, rise, press_now, hit_l, hit_r, hit_t, hit_p, hit_b;
   logic signed [10:0] mag, dx, dy, nx, ny, bot;
   logic [10:0]       serve_sum;

   btn_sync_edge u_launch (.clk(CLK_25MH), .rst_n(RST_N), .btn_in(btn_launch), .rise(rise));

`ifdef BALL_SPEEDUP_EN
   logic [2:0] spd_q, spd_d, hits_q, hits_d;
   logic       bump;
   always_comb begin
      bump   = tick && state_q == PLAY && hit_p;
      hits_d = bump ? hits_q + 3'd1 : hits_q;
      spd_d  = (state_d == SERVE && state_q != SERVE) ? 3'(SPEED) :
               (bump && hits_q == 3'd7 && spd_q != 3'd7) ? spd_q + 3'd1 : spd_q;
   end
   always_ff @(posedge CLK_25MH or negedge RST_N)
      if (!RST_N) begin
         spd_q  <= 3'(SPEED);
         hits_q <= '0;
      end else begin
         spd_q  <= spd_d;
         hits_q <= hits_d;
      end
   assign spd = spd_q;
`else
   assign spd = 3'(SPEED);
`endif

   assign tick      = hor_count == 10'd0 && ver_count == 10'(FRAME_TICK_LINE);
   // a press arriving on the tick cycle itself is honoured rather than lost
   assign press_now = press_q | rise;
   assign mag       = $signed({8'd0, spd});
   assign dx        = dx_neg_q ? -mag : mag;
   assign dy        = dy_neg_q ? -mag : mag;
   assign nx        = $signed({1'b0, x_q}) + dx;
   assign ny        = $signed({1'b0, y_q}) + dy;
   assign bot       = ny + 11'(BALL_SIZE);
   assign serve_sum = {1'b0, paddle_pos} + SRV_OFS;
   assign serve_x   = serve_sum > 11'(X_MAX) ? 10'(X_MAX) : serve_sum[9:0];
   assign hit_l     = nx <= 11'sd0;
   assign hit_r     = nx >= X_MAX;
   assign px        = hit_l ? 10'd0 : hit_r ? 10'(X_MAX) : nx[9:0];
   assign hit_t     = ny <= 11'sd0;
   // paddle overlap is judged on the wall-clamped x of this tick
   assign hit_p     = !dy_neg_q && bot >= 11'(PADDLE_Y_TOP) && bot <= 11'(PADDLE_Y_BOT) &&
                      {1'b0, px} + 11'(BALL_SIZE) > {1'b0, paddle_pos} &&
                      {1'b0, px} < {1'b0, paddle_pos} + 11'(PADDLE_W);
   assign hit_b     = ny >= Y_BOT;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_neg_d = dx_neg_q;
      dy_neg_d = dy_neg_q;
      lives_d  = lives_q;
      press_d  = tick ? 1'b0 : press_now;
      if (tick)
         case (state_q)
            SERVE: begin
               x_d = serve_x;
               y_d = Y_SERVE;
               if (press_now) begin
                  state_d  = PLAY;
                  dx_neg_d = 1'b0;
                  dy_neg_d = 1'b1;
               end
            end
            PLAY: begin
               x_d      = px;
               dx_neg_d = hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg_q;
               y_d      = hit_t ? 10'd0 : hit_p ? Y_SERVE : ny[9:0];
               dy_neg_d = hit_t ? 1'b0 : hit_p ? 1'b1 : dy_neg_q;
               if (hit_b && !hit_p) state_d = LOST;
            end
            LOST: begin
               lives_d = lives_q - 2'd1;
               state_d = lives_q == 2'd1 ? OVER : SERVE;
            end
            default: if (press_now) begin
               lives_d = 2'(LIVES_INIT);
               state_d = SERVE;
            end
         endcase
      rgb_d = (hor_count >= x_q && hor_count < x_q + 10'(BALL_SIZE) &&
               ver_count >= y_q && ver_count < y_q + 10'(BALL_SIZE) &&
               hor_count < 10'(H_VISIBLE) && ver_count < 10'(V_VISIBLE) &&
               state_q != OVER) ? BALL_RGB : 3'b000;
   end

   always_ff @(posedge CLK_25MH or negedge RST_N)
      if (!RST_N) begin
         state_q  <= SERVE;
         x_q      <= '0;
         y_q      <= Y_SERVE;
         dx_neg_q <= 1'b0;
         dy_neg_q <= 1'b1;
         lives_q  <= 2'(LIVES_INIT);
         press_q  <= 1'b0;
         rgb_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_neg_q <= dx_neg_d;
         dy_neg_q <= dy_neg_d;
         lives_q  <= lives_d;
         press_q  <= press_d;
         rgb_q    <= rgb_d;
      end

   assign rgb_out   = rgb_q;
   assign ball_x    = x_q;
   assign ball_y    = y_q;
   assign lives     = lives_q;
   assign game_over = state_q == OVER;
endmodule
